issue_controller: RTL and testbench
===================================

ISSUE_CONTROLLER -- requirements
Module: issue_controller

Interface
REQ-001 SHALL have parameter PCbitsize, default 32, giving the width of all PC ports.
REQ-002 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port pair_valid  in  1  IF/ID stage holds a valid instruction pair.
REQ-005 SHALL have ports first_instruction, second_instruction  in  32  older and younger instruction of the pair.
REQ-006 SHALL have ports first_pipe, second_pipe  in  1  pipe class of each instruction (0 = even, 1 = odd).
REQ-007 SHALL have port raw_dep  in  1  second instruction reads the destination of the first.
REQ-008 SHALL have ports hazard_first, hazard_second  in  1  operand not yet available from an older in-flight instruction.
REQ-009 SHALL have port exec_stall  in  1  execute stages cannot accept issue this cycle.
REQ-010 SHALL have port flush  in  1  taken branch; discard the pair.
REQ-011 SHALL have port PC_plusEight  in  PCbitsize  PC of the first instruction plus 8.
REQ-012 SHALL have ports even_valid, odd_valid  out  1  registered issue strobe per pipe.
REQ-013 SHALL have ports even_instr, odd_instr  out  32  registered issued instruction per pipe.
REQ-014 SHALL have ports even_pc, odd_pc  out  PCbitsize  registered PC of the issued instruction.
REQ-015 SHALL have port if_stall  out  1  combinational; hold PC and IF/ID when high.
REQ-016 SHALL have port issue_count  out  32  running count of issued instructions.

Function
REQ-017 SHALL implement two states: PAIR (no instruction of the current pair issued) and SECOND (first instruction issued, second pending).
REQ-018 SHALL register the issue outputs with 1-cycle latency: a decision made in cycle N appears on the *_valid, *_instr and *_pc outputs after edge N+1.
REQ-019 SHALL apply the following rules in PAIR when pair_valid=1, flush=0 and exec_stall=0, in priority order:
  a. hazard_first=1: issue nothing; if_stall=1; remain in PAIR.
  b. first_pipe!=second_pipe, raw_dep=0 and hazard_second=0: dual-issue both instructions, each to its own pipe; if_stall=0; remain in PAIR.
  c. Otherwise: issue the first instruction only; if_stall=1; go to SECOND.
REQ-020 SHALL apply the following rules in SECOND when flush=0 and exec_stall=0:
  a. hazard_second=1: issue nothing; if_stall=1.
  b. Otherwise: issue the second instruction on second_pipe; if_stall=0; go to PAIR.
  In SECOND, raw_dep and pair_valid SHALL be ignored.
REQ-021 SHALL, in PAIR with pair_valid=0, issue nothing and drive if_stall=0.
REQ-022 SHALL, when exec_stall=1 and flush=0, issue nothing, drive if_stall=1 and hold the state.
REQ-023 SHALL give flush priority over all other inputs: issue nothing, drive if_stall=0 and go to PAIR next.
REQ-024 SHALL compute issued PCs modulo 2^PCbitsize, with wrap-around permitted: the first instruction's PC is PC_plusEight-8 and the second's is PC_plusEight-4.
REQ-025 SHALL deassert a pipe's *_valid in every cycle that nothing is issued to that pipe; *_instr and *_pc may then hold stale values.
REQ-026 SHALL increment issue_count by 0, 1 or 2 per issue decision, wrapping modulo 2^32 without saturating.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state=PAIR, even_valid=0, odd_valid=0, even_instr=0, odd_instr=0, even_pc=0, odd_pc=0 and issue_count=0.
REQ-028 SHALL hold if_stall=0 throughout reset; the first issue decision SHALL be taken in the first cycle with rst_n=1.
REQ-029 SHALL, on reset asserted mid-operation (state SECOND), abandon the pending second instruction without issuing it.

Verification
REQ-030 SHALL cover dual issue: PC_plusEight=0x108, first_pipe=0, second_pipe=1, no dep/hazard -> next cycle even_valid=1, even_pc=0x100, odd_valid=1, odd_pc=0x104, if_stall=0, issue_count+=2.
REQ-031 SHALL cover same-pipe split: both pipes=1 -> cycle 1: odd_pc=PC-8 with if_stall=1; cycle 2: odd_pc=PC-4 with if_stall=0; issue_count+=1 each cycle.
REQ-032 SHALL cover RAW split and hazard hold: raw_dep=1 and hazard_second=1 for 3 cycles -> first issued, then 3 cycles of no issue with if_stall=1, then second issued.
REQ-033 SHALL cover flush in SECOND: flush=1 -> no second issue, if_stall=0, state PAIR; next pair issues normally.
REQ-034 SHALL cover PC wrap: PC_plusEight=0x4 -> first PC 0xFFFFFFFC, second PC 0x00000000.
REQ-035 SHALL cover async reset: rst_n low mid-cycle while in SECOND -> all outputs 0 immediately, without waiting for a clk edge; issue_count=0.

Source files
------------

// File: rtl/issue_controller.sv
// Dual-issue controller: steers an in-order instruction pair to the even/odd
// execute pipes, splitting the pair over two cycles when it cannot dual-issue.
module issue_controller #(
    parameter int PCbitsize = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pair_valid,
    input  logic [31:0]          first_instruction,
    input  logic [31:0]          second_instruction,
    input  logic                 first_pipe,
    input  logic                 second_pipe,
    input  logic                 raw_dep,
    input  logic                 hazard_first,
    input  logic                 hazard_second,
    input  logic                 exec_stall,
    input  logic                 flush,
    input  logic [PCbitsize-1:0] PC_plusEight,
    output logic                 even_valid,
    output logic                 odd_valid,
    output logic [31:0]          even_instr,
    output logic [31:0]          odd_instr,
    output logic [PCbitsize-1:0] even_pc,
    output logic [PCbitsize-1:0] odd_pc,
    output logic                 if_stall,
    output logic [31:0]          issue_count
);

    typedef enum logic {PAIR = 1'b0, SECOND = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic                   issue_first, issue_second, stall;
    logic                   even_valid_d, odd_valid_d;
    logic [31:0]            even_instr_d, odd_instr_d;
    logic [PCbitsize-1:0]   even_pc_d, odd_pc_d;
    logic [PCbitsize-1:0]   pc_first, pc_second;
    logic [1:0]             n_issued;

    assign pc_first  = PC_plusEight - PCbitsize'(8);
    assign pc_second = PC_plusEight - PCbitsize'(4);

    always_comb begin
        issue_first  = 1'b0;
        issue_second = 1'b0;
        stall        = 1'b0;
        state_d      = state_q;
        if (flush) begin
            state_d = PAIR;
        end else if (exec_stall) begin
            stall = 1'b1;
        end else if (state_q == PAIR) begin
            if (pair_valid) begin
                if (hazard_first) begin
                    stall = 1'b1;
                end else if (first_pipe != second_pipe && !raw_dep && !hazard_second) begin
                    issue_first  = 1'b1;
                    issue_second = 1'b1;
                end else begin
                    issue_first = 1'b1;
                    stall       = 1'b1;
                    state_d     = SECOND;
                end
            end
        end else begin
            if (hazard_second) begin
                stall = 1'b1;
            end else begin
                issue_second = 1'b1;
                state_d      = PAIR;
            end
        end
    end

    // Dual issue only happens with distinct pipes, so the two routes never collide.
    always_comb begin
        even_valid_d = 1'b0;
        odd_valid_d  = 1'b0;
        even_instr_d = even_instr;
        odd_instr_d  = odd_instr;
        even_pc_d    = even_pc;
        odd_pc_d     = odd_pc;
        if (issue_first) begin
            if (first_pipe) begin
                odd_valid_d  = 1'b1;
                odd_instr_d  = first_instruction;
                odd_pc_d     = pc_first;
            end else begin
                even_valid_d = 1'b1;
                even_instr_d = first_instruction;
                even_pc_d    = pc_first;
            end
        end
        if (issue_second) begin
            if (second_pipe) begin
                odd_valid_d  = 1'b1;
                odd_instr_d  = second_instruction;
                odd_pc_d     = pc_second;
            end else begin
                even_valid_d = 1'b1;
                even_instr_d = second_instruction;
                even_pc_d    = pc_second;
            end
        end
    end

    assign n_issued = {1'b0, issue_first} + {1'b0, issue_second};
    assign if_stall = stall & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PAIR;
            even_valid  <= 1'b0;
            odd_valid   <= 1'b0;
            even_instr  <= '0;
            odd_instr   <= '0;
            even_pc     <= '0;
            odd_pc      <= '0;
            issue_count <= '0;
        end else begin
            state_q     <= state_d;
            even_valid  <= even_valid_d;
            odd_valid   <= odd_valid_d;
            even_instr  <= even_instr_d;
            odd_instr   <= odd_instr_d;
            even_pc     <= even_pc_d;
            odd_pc      <= odd_pc_d;
            issue_count <= issue_count + 32'(n_issued);
        end
    end

endmodule

// File: tb/tb_issue_controller.sv
// Bench for issue_controller: directed pair sequences, a per-cycle reference
// model of the issue rules, and literal spot checks of known outcomes.
module tb_issue_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pair_valid = 1'b0;
    logic [31:0] first_instruction = '0, second_instruction = '0;
    logic        first_pipe = 1'b0, second_pipe = 1'b0;
    logic        raw_dep = 1'b0, hazard_first = 1'b0, hazard_second = 1'b0;
    logic        exec_stall = 1'b0, flush = 1'b0;
    logic [31:0] PC_plusEight = '0;
    logic        even_valid, odd_valid, if_stall;
    logic [31:0] even_instr, odd_instr, even_pc, odd_pc, issue_count;

    issue_controller #(.PCbitsize(32)) dut (
        .clk(clk), .rst_n(rst_n), .pair_valid(pair_valid),
        .first_instruction(first_instruction), .second_instruction(second_instruction),
        .first_pipe(first_pipe), .second_pipe(second_pipe), .raw_dep(raw_dep),
        .hazard_first(hazard_first), .hazard_second(hazard_second),
        .exec_stall(exec_stall), .flush(flush), .PC_plusEight(PC_plusEight),
        .even_valid(even_valid), .odd_valid(odd_valid),
        .even_instr(even_instr), .odd_instr(odd_instr),
        .even_pc(even_pc), .odd_pc(odd_pc),
        .if_stall(if_stall), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        ev, ov;
        logic [31:0] ei, oi, ep, op;
        logic [31:0] add;
        logic        stall;
        logic        pend;
    } dec_t;

    // pend = the older instruction of the held pair has already gone out.
    function automatic dec_t decide(input logic pend);
        dec_t d;
        logic take[2];
        logic pipe[2];
        logic [31:0] ins[2];
        d = '{default: 0};
        d.pend = pend;
        take[0] = 1'b0;
        take[1] = 1'b0;
        pipe[0] = first_pipe;
        pipe[1] = second_pipe;
        ins[0]  = first_instruction;
        ins[1]  = second_instruction;
        if (flush) begin
            d.pend = 1'b0;
        end else if (exec_stall) begin
            d.stall = 1'b1;
        end else if (!pend) begin
            if (pair_valid) begin
                if (hazard_first) d.stall = 1'b1;
                else if (first_pipe != second_pipe && !raw_dep && !hazard_second) begin
                    take[0] = 1'b1;
                    take[1] = 1'b1;
                end else begin
                    take[0] = 1'b1;
                    d.stall = 1'b1;
                    d.pend  = 1'b1;
                end
            end
        end else if (hazard_second) begin
            d.stall = 1'b1;
        end else begin
            take[1] = 1'b1;
            d.pend  = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            if (take[k]) begin
                d.add = d.add + 1;
                if (pipe[k]) begin
                    d.ov = 1'b1; d.oi = ins[k]; d.op = PC_plusEight - 32'd8 + 32'(4 * k);
                end else begin
                    d.ev = 1'b1; d.ei = ins[k]; d.ep = PC_plusEight - 32'd8 + 32'(4 * k);
                end
            end
        end
        return d;
    endfunction

    logic        m_pend = 1'b0, m_ev = 1'b0, m_ov = 1'b0;
    logic [31:0] m_ei = '0, m_oi = '0, m_ep = '0, m_op = '0, m_cnt = '0;
    dec_t        cur;

    always_comb cur = decide(m_pend);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0; m_ev <= 1'b0; m_ov <= 1'b0; m_cnt <= '0;
            m_ei <= '0; m_oi <= '0; m_ep <= '0; m_op <= '0;
        end else begin
            m_pend <= cur.pend;
            m_ev   <= cur.ev;
            m_ov   <= cur.ov;
            if (cur.ev) begin m_ei <= cur.ei; m_ep <= cur.ep; end
            if (cur.ov) begin m_oi <= cur.oi; m_op <= cur.op; end
            m_cnt  <= m_cnt + cur.add;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("even_valid", {31'd0, even_valid}, {31'd0, m_ev});
            check("odd_valid", {31'd0, odd_valid}, {31'd0, m_ov});
            if (m_ev) begin
                check("even_instr", even_instr, m_ei);
                check("even_pc", even_pc, m_ep);
            end
            if (m_ov) begin
                check("odd_instr", odd_instr, m_oi);
                check("odd_pc", odd_pc, m_op);
            end
            check("issue_count", issue_count, m_cnt);
            check("if_stall", {31'd0, if_stall}, {31'd0, cur.stall & rst_n});
        end
    end

    // Apply one cycle of inputs, pin if_stall, then return just after the consuming edge.
    task automatic cyc(input string name, input logic pv, input logic fp, input logic sp,
                       input logic raw, input logic hf, input logic hs, input logic es,
                       input logic fl, input logic [31:0] pc8, input logic exp_stall);
        pair_valid = pv; first_pipe = fp; second_pipe = sp; raw_dep = raw;
        hazard_first = hf; hazard_second = hs; exec_stall = es; flush = fl;
        PC_plusEight = pc8;
        first_instruction  = 32'hA000_0000 | pc8;
        second_instruction = 32'hB000_0000 | pc8;
        #1;
        check({name, "_if_stall"}, {31'd0, if_stall}, {31'd0, exp_stall});
        $display("cycle %-10s pv=%0b fp=%0b sp=%0b raw=%0b hf=%0b hs=%0b es=%0b fl=%0b pc8=0x%08h stall=%0b",
                 name, pv, fp, sp, raw, hf, hs, es, fl, pc8, if_stall);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        pair_valid = 1'b1; hazard_first = 1'b1;
        #1;
        check("rst_even_valid", {31'd0, even_valid}, 32'd0);
        check("rst_odd_pc", odd_pc, 32'd0);
        check("rst_issue_count", issue_count, 32'd0);
        check("rst_if_stall", {31'd0, if_stall}, 32'd0);
        cmp_en = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;

        cyc("dual", 1, 0, 1, 0, 0, 0, 0, 0, 32'h108, 0);
        check("dual_even_pc", even_pc, 32'h100);
        check("dual_odd_pc", odd_pc, 32'h104);
        check("dual_even_instr", even_instr, 32'hA000_0108);
        check("dual_odd_instr", odd_instr, 32'hB000_0108);
        check("dual_count", issue_count, 32'd2);

        cyc("same1", 1, 1, 1, 0, 0, 0, 0, 0, 32'h208, 1);
        check("same1_odd_pc", odd_pc, 32'h200);
        check("same1_even_valid", {31'd0, even_valid}, 32'd0);
        check("same1_count", issue_count, 32'd3);
        cyc("same2", 1, 1, 1, 0, 0, 0, 0, 0, 32'h208, 0);
        check("same2_odd_pc", odd_pc, 32'h204);
        check("same2_count", issue_count, 32'd4);

        cyc("raw", 1, 0, 1, 1, 0, 1, 0, 0, 32'h308, 1);
        check("raw_even_pc", even_pc, 32'h300);
        for (int i = 0; i < 3; i++) begin
            cyc("hold", 1, 0, 1, 1, 0, 1, 0, 0, 32'h308, 1);
            check("hold_odd_valid", {31'd0, odd_valid}, 32'd0);
            check("hold_count", issue_count, 32'd5);
        end
        cyc("release", 1, 0, 1, 1, 0, 0, 0, 0, 32'h308, 0);
        check("release_odd_pc", odd_pc, 32'h304);
        check("release_count", issue_count, 32'd6);

        cyc("preflush", 1, 0, 0, 0, 0, 0, 0, 0, 32'h408, 1);
        cyc("flush", 1, 0, 0, 0, 0, 0, 0, 1, 32'h408, 0);
        check("flush_even_valid", {31'd0, even_valid}, 32'd0);
        check("flush_count", issue_count, 32'd7);
        cyc("postflush", 1, 1, 0, 0, 0, 0, 0, 0, 32'h508, 0);
        check("postflush_odd_pc", odd_pc, 32'h500);
        check("postflush_even_pc", even_pc, 32'h504);
        check("postflush_count", issue_count, 32'd9);

        cyc("wrap1", 1, 0, 0, 0, 0, 0, 0, 0, 32'h4, 1);
        check("wrap1_even_pc", even_pc, 32'hFFFF_FFFC);
        cyc("wrap2", 1, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0);
        check("wrap2_even_pc", even_pc, 32'h0);
        check("wrap2_count", issue_count, 32'd11);

        cyc("execstall", 1, 0, 1, 0, 0, 0, 1, 0, 32'h808, 1);
        cyc("novalid", 0, 0, 1, 0, 0, 0, 0, 0, 32'h808, 0);
        cyc("hazfirst", 1, 0, 1, 0, 1, 0, 0, 0, 32'h808, 1);
        check("hazfirst_count", issue_count, 32'd11);

        cyc("preset", 1, 1, 1, 0, 0, 0, 0, 0, 32'h608, 1);
        check("preset_count", issue_count, 32'd12);
        #1 rst_n = 1'b0;
        #1;
        check("arst_odd_valid", {31'd0, odd_valid}, 32'd0);
        check("arst_odd_pc", odd_pc, 32'd0);
        check("arst_odd_instr", odd_instr, 32'd0);
        check("arst_even_pc", even_pc, 32'd0);
        check("arst_count", issue_count, 32'd0);
        check("arst_if_stall", {31'd0, if_stall}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc("after_rst", 1, 1, 1, 0, 0, 0, 0, 0, 32'h708, 1);
        check("after_rst_odd_pc", odd_pc, 32'h700);
        check("after_rst_count", issue_count, 32'd1);
        cyc("after_rst2", 1, 1, 1, 0, 0, 0, 0, 0, 32'h708, 0);
        check("after_rst2_odd_pc", odd_pc, 32'h704);
        cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        check("idle_count", issue_count, 32'd2);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
